// File: rtl/alu_pipe.sv
// alu_pipe: registered Hack-style ALU with carry/overflow flags, an optional
// iterative shift-add multiplier, and valid/ready handshakes on both sides.
// One result is buffered at the output; a new operation is only taken when
// that buffer is empty or being drained in the same cycle.
module alu_pipe #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, MUL} state_t;

  // Zero then optionally invert an operand, as the Hack ALU does.
  function automatic logic signed [WIDTH-1:0] prep(input logic signed [WIDTH-1:0] v,
                                                   input logic z, input logic n);
    logic signed [WIDTH-1:0] t;
    t = z ? '0 : v;
    return n ? ~t : t;
  endfunction

  // Optional final inversion of the result.
  function automatic logic signed [WIDTH-1:0] post(input logic signed [WIDTH-1:0] r,
                                                   input logic n);
    return n ? ~r : r;
  endfunction

  state_t                  state;
  logic                    vld_p1;
  logic signed [WIDTH-1:0] res_p1;
  logic        [WIDTH-1:0] mcand;
  logic        [WIDTH-1:0] mplier;
  logic        [WIDTH-1:0] acc;
  logic        [CNT_W-1:0] cnt;
  logic                    no_m;

  // ---- stage p0: operand preprocessing and combinational ALU ----
  logic signed [WIDTH-1:0] px_p0;
  logic signed [WIDTH-1:0] py_p0;
  logic        [WIDTH:0]   sum_p0;
  logic signed [WIDTH-1:0] alu_p0;
  logic                    carry_p0;
  logic                    ovf_p0;
  logic                    mul_p0;
  logic                    accept_p0;
  logic        [WIDTH-1:0] acc_nxt;
  logic signed [WIDTH-1:0] mres;

  assign px_p0     = prep(x, zx, nx);
  assign py_p0     = prep(y, zy, ny);
  assign sum_p0    = {1'b0, px_p0} + {1'b0, py_p0};
  assign alu_p0    = post(f ? sum_p0[WIDTH-1:0] : (px_p0 & py_p0), no);
  assign carry_p0  = f & sum_p0[WIDTH];
  assign ovf_p0    = f & (px_p0[WIDTH-1] == py_p0[WIDTH-1])
                       & (sum_p0[WIDTH-1] != px_p0[WIDTH-1]);
  assign mul_p0    = MUL_EN ? mul : 1'b0;
  assign in_ready  = (state == IDLE) & (~vld_p1 | out_ready);
  assign accept_p0 = in_valid & in_ready;
  assign acc_nxt   = acc + (mplier[0] ? mcand : '0);
  assign mres      = post(acc_nxt, no_m);

  // ---- stage p1: result register, flags, and multiply sequencer ----
  // Single FSM owning the output buffer and the shift-add iteration state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      vld_p1 <= 1'b0;
      res_p1 <= '0;
      zr     <= 1'b0;
      ng     <= 1'b0;
      cy     <= 1'b0;
      ov     <= 1'b0;
      busy   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      no_m   <= 1'b0;
    end else if (state == IDLE) begin
      if (accept_p0) begin
        if (mul_p0) begin
          // Any previous result was consumed this edge, so the buffer empties.
          state  <= MUL;
          mcand  <= px_p0;
          mplier <= py_p0;
          acc    <= '0;
          cnt    <= CNT_W'(WIDTH);
          no_m   <= no;
          busy   <= 1'b1;
          vld_p1 <= 1'b0;
        end else begin
          res_p1 <= alu_p0;
          zr     <= (alu_p0 == '0);
          ng     <= alu_p0[WIDTH-1];
          cy     <= carry_p0;
          ov     <= ovf_p0;
          vld_p1 <= 1'b1;
        end
      end else if (vld_p1 && out_ready) begin
        vld_p1 <= 1'b0;
      end
    end else begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        // Last partial product folded in: publish the low WIDTH bits.
        res_p1 <= mres;
        zr     <= (mres == '0);
        ng     <= mres[WIDTH-1];
        cy     <= 1'b0;
        ov     <= 1'b0;
        vld_p1 <= 1'b1;
        busy   <= 1'b0;
        state  <= IDLE;
      end
    end
  end

  assign out       = res_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe at WIDTH=16: directed scenarios plus a
// randomized stream scored against an arithmetic reference model.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic        zx, nx, zy, ny, f, no, mul;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        zr, ng, cy, ov, busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  alu_pipe #(.WIDTH(16), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .mul(mul),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zr(zr), .ng(ng), .cy(cy), .ov(ov), .busy(busy)
  );

  always #5 clk = ~clk;

  // Hack control codes {zx,nx,zy,ny,f,no}: 0,1,-1,x,y,!x,-x,x+1,x-1,x+y,x-y,x&y,x|y
  localparam logic [5:0] CODES [13] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100,
                                        6'b110000, 6'b001101, 6'b001111, 6'b011111,
                                        6'b001110, 6'b000010, 6'b010011, 6'b000000,
                                        6'b010101};
  localparam logic [15:0] TBL_EXP [13] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0005,
                                           16'h0003, 16'hFFFA, 16'hFFFB, 16'h0006,
                                           16'h0004, 16'h0008, 16'h0002, 16'h0001,
                                           16'h0007};

  // Reference: returns {cy, ov, out} from the ALU rules using integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [5:0] c, input logic m);
    logic [15:0] px, py, r;
    int unsigned ua, ub, prod, usum;
    int sa, sb, ssum;
    logic c_o, v_o;
    px = c[5] ? 16'h0 : a;
    if (c[4]) px = ~px;
    py = c[3] ? 16'h0 : b;
    if (c[2]) py = ~py;
    ua = px; ub = py;
    sa = $signed(px); sb = $signed(py);
    c_o = 1'b0; v_o = 1'b0;
    if (m) begin
      prod = ua * ub;
      r = prod[15:0];
    end else if (c[1]) begin
      usum = ua + ub;
      ssum = sa + sb;
      r = usum[15:0];
      c_o = (usum > 32'd65535);
      v_o = (ssum > 32767) || (ssum < -32768);
    end else begin
      r = px & py;
    end
    if (c[0]) r = ~r;
    return {c_o, v_o, r};
  endfunction

  task automatic set_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [5:0] c, input logic m);
    x = a; y = b;
    {zx, nx, zy, ny, f, no} = c;
    mul = m;
  endtask

  task automatic idle_cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    chk_cnt++;
    if ({out_valid, busy, out, zr, ng, cy, ov} !== 22'h0)
      $display("FAIL reset_hold: got v=%b b=%b out=%h zr=%b ng=%b cy=%b ov=%b want all 0",
               out_valid, busy, out, zr, ng, cy, ov);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
    set_op(16'hFFFF, 16'hFFFF, 6'b000010, 1'b0);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk_cnt++;
    if (!(out_valid === 1'b1 && out === 16'hFFFE && cy === 1'b1 && ng === 1'b1 && ov === 1'b0))
      $display("FAIL pre_reset_op: got v=%b out=%h cy=%b ng=%b ov=%b want 1 fffe 1 1 0",
               out_valid, out, cy, ng, ov);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({out_valid, busy, out, zr, ng, cy, ov} !== 22'h0)
      $display("FAIL async_reset: got v=%b b=%b out=%h zr=%b ng=%b cy=%b ov=%b want all 0",
               out_valid, busy, out, zr, ng, cy, ov);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL post_reset: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_alu_table();
    logic [17:0] m;
    idle_cycle();
    for (int i = 0; i < 13; i++) begin
      set_op(16'd5, 16'd3, CODES[i], 1'b0);
      m = model(16'd5, 16'd3, CODES[i], 1'b0);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk_cnt++;
      if (!(out_valid === 1'b1 && out === TBL_EXP[i] && zr === (TBL_EXP[i] == 16'h0)
            && ng === TBL_EXP[i][15]))
        $display("FAIL alu_tbl_%0d: got v=%b out=%h zr=%b ng=%b want v=1 out=%h",
                 i, out_valid, out, zr, ng, TBL_EXP[i]);
      else pass_cnt++;
      chk_cnt++;
      if (cy !== m[17] || ov !== m[16])
        $display("FAIL alu_flags_%0d: got cy=%b ov=%b want cy=%b ov=%b", i, cy, ov, m[17], m[16]);
      else pass_cnt++;
    end
  endtask

  task automatic test_flags();
    idle_cycle();
    set_op(16'h7FFF, 16'h0001, 6'b000010, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    set_op(16'hFFFF, 16'h0001, 6'b000010, 1'b0);
    chk_cnt++;
    if (!(out_valid === 1'b1 && out === 16'h8000 && ng === 1'b1 && ov === 1'b1
          && cy === 1'b0 && zr === 1'b0))
      $display("FAIL flags_ovf: got out=%h ng=%b ov=%b cy=%b zr=%b want 8000 1 1 0 0",
               out, ng, ov, cy, zr);
    else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
    chk_cnt++;
    if (!(out_valid === 1'b1 && out === 16'h0000 && zr === 1'b1 && cy === 1'b1
          && ov === 1'b0 && ng === 1'b0))
      $display("FAIL flags_carry: got out=%h zr=%b cy=%b ov=%b ng=%b want 0000 1 1 0 0",
               out, zr, cy, ov, ng);
    else pass_cnt++;
  endtask

  task automatic test_mul();
    idle_cycle();
    set_op(16'd7, 16'hFFFD, 6'b000000, 1'b1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      chk_cnt++;
      if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL mul_busy_%0d: got v=%b busy=%b in_ready=%b want 0 1 0",
                 k, out_valid, busy, in_ready);
      else pass_cnt++;
      @(negedge clk);
    end
    chk_cnt++;
    if (!(out_valid === 1'b1 && out === 16'hFFEB && ng === 1'b1 && zr === 1'b0
          && busy === 1'b0 && cy === 1'b0 && ov === 1'b0))
      $display("FAIL mul_result: got v=%b out=%h ng=%b busy=%b cy=%b ov=%b want 1 ffeb 1 0 0 0",
               out_valid, out, ng, busy, cy, ov);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [15:0] ex [$];
    logic [15:0] ax [3];
    logic [15:0] bx [3];
    logic [15:0] hold = '0;
    logic [15:0] want;
    logic [17:0] m;
    logic holding = 1'b0;
    int issued = 0;
    int got = 0;
    idle_cycle();
    for (int i = 0; i < 3; i++) begin
      ax[i] = 16'($urandom);
      bx[i] = 16'($urandom);
    end
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      @(negedge clk);
      if (holding) begin
        chk_cnt++;
        if (out_valid !== 1'b1 || out !== hold)
          $display("FAIL bp_hold_%0d: got v=%b out=%h want 1 %h", cyc, out_valid, out, hold);
        else pass_cnt++;
      end
      out_ready = (cyc >= 5);
      #1;
      if (out_valid && out_ready) begin
        want = ex.pop_front();
        chk_cnt++;
        if (out !== want) $display("FAIL bp_data_%0d: got %h want %h", got, out, want);
        else pass_cnt++;
        got++;
        holding = 1'b0;
      end else if (out_valid) begin
        hold = out;
        holding = 1'b1;
        chk_cnt++;
        if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready);
        else pass_cnt++;
      end
      if (issued < 3) begin
        set_op(ax[issued], bx[issued], 6'b000010, 1'b0);
        in_valid = 1'b1;
        if (in_ready) begin
          m = model(ax[issued], bx[issued], 6'b000010, 1'b0);
          ex.push_back(m[15:0]);
          issued++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_cnt++;
    if (got != 3 || issued != 3 || ex.size() != 0 || out_valid !== 1'b0)
      $display("FAIL bp_count: got issued=%0d received=%0d pending=%0d v=%b want 3 3 0 0",
               issued, got, ex.size(), out_valid);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    logic seen = 1'b0;
    idle_cycle();
    set_op(16'd123, 16'd45, 6'b000000, 1'b1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL abort_reset: got busy=%b v=%b in_ready=%b want 0 0 1",
               busy, out_valid, in_ready);
    else pass_cnt++;
    #1 rst_n = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    chk_cnt++;
    if (seen !== 1'b0) $display("FAIL abort_no_result: got output activity=%b want 0", seen);
    else pass_cnt++;
    set_op(16'd2, 16'd3, 6'b000010, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk_cnt++;
    if (out_valid !== 1'b1 || out !== 16'd5 || cy !== 1'b0 || ov !== 1'b0)
      $display("FAIL abort_next_add: got v=%b out=%h cy=%b ov=%b want 1 0005 0 0",
               out_valid, out, cy, ov);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [17:0] ex [$];
    logic [17:0] want;
    logic [15:0] ra = '0, rb = '0, hold = '0;
    logic [5:0]  rc = '0;
    logic        rm = 1'b0;
    logic        have = 1'b0;
    logic        holding = 1'b0;
    int issued = 0;
    int got = 0;
    int errs = 0;
    idle_cycle();
    for (int cyc = 0; cyc < 4000 && got < 60; cyc++) begin
      @(negedge clk);
      if (holding && (out_valid !== 1'b1 || out !== hold)) errs++;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        holding = 1'b0;
        if (ex.size() == 0) begin
          errs++;
        end else begin
          want = ex.pop_front();
          chk_cnt++;
          if ({cy, ov, out} !== want || zr !== (want[15:0] == 16'h0) || ng !== want[15])
            $display("FAIL rand_%0d: got cy=%b ov=%b out=%h zr=%b ng=%b want cy=%b ov=%b out=%h",
                     got, cy, ov, out, zr, ng, want[17], want[16], want[15:0]);
          else pass_cnt++;
        end
        got++;
      end else if (out_valid) begin
        holding = 1'b1;
        hold = out;
      end
      if (!have && issued < 60) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = CODES[$urandom_range(0, 12)];
        rm = ($urandom_range(0, 4) == 0);
        have = 1'b1;
      end
      if (have && $urandom_range(0, 4) != 0) begin
        set_op(ra, rb, rc, rm);
        in_valid = 1'b1;
        if (in_ready) begin
          ex.push_back(model(ra, rb, rc, rm));
          issued++;
          have = 1'b0;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk_cnt++;
    if (got != 60 || errs != 0)
      $display("FAIL rand_stream: got received=%0d protocol_errors=%0d want 60 0", got, errs);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_op(16'h0, 16'h0, 6'b0, 1'b0);
    test_reset();
    test_alu_table();
    test_flags();
    test_mul();
    test_backpressure();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
